button_conditioner: RTL and testbench

- Input-side companion to the LED/PMOD output logic: conditions the raw iCEBreaker buttons into clean, debounced levels and single-cycle events.
- Per-button path: 2-flop synchronizer -> polarity normalisation -> debounce counter -> press/held FSM.
- Outputs: debounced levels, press/release/long-press pulses, and a wrapping total press counter that top-level logic can route to the LEDs.

---
 rtl/button_conditioner.sv | 107 ++++++++++
 tb/tb_button_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button conditioner: synchronises, normalises and debounces raw buttons, then
// derives press / release / long-press pulses and a wrapping press counter.
module button_conditioner #(
   parameter int              NBTN          = 4,
   parameter logic [NBTN-1:0] ACTIVE_LOW    = {{(NBTN-1){1'b0}}, 1'b1},
   parameter int              DEBOUNCE_LOG2 = 16,
   parameter int              LONG_LOG2     = 23
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [NBTN-1:0] BTN_RAW,
   output logic [NBTN-1:0] BTN_LEVEL,
   output logic [NBTN-1:0] BTN_PRESS,
   output logic [NBTN-1:0] BTN_RELEASE,
   output logic [NBTN-1:0] BTN_LONG,
   output logic [7:0]      PRESS_COUNT
);

   typedef enum logic [1:0] {IDLE, DOWN, HELD} state_t;

   logic [NBTN-1:0]          sync_p0, sync_p1;
   logic [NBTN-1:0]          norm;
   logic [NBTN-1:0]          level_nxt, press_nxt, release_nxt;
   logic [DEBOUNCE_LOG2-1:0] dcnt  [NBTN];
   logic [LONG_LOG2-1:0]     lcnt  [NBTN];
   state_t                   state [NBTN];

   function automatic logic [7:0] popcount(input logic [NBTN-1:0] v);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < NBTN; i++) c = c + {7'd0, v[i]};
      return c;
   endfunction

   assign norm = sync_p1 ^ ACTIVE_LOW;

   // Level toggles only once the disagreeing input has filled the debounce counter.
   always_comb begin
      level_nxt = BTN_LEVEL;
      for (int i = 0; i < NBTN; i++) begin
         if ((norm[i] != BTN_LEVEL[i]) && (&dcnt[i])) level_nxt[i] = ~BTN_LEVEL[i];
      end
   end

   assign press_nxt   = level_nxt & ~BTN_LEVEL;
   assign release_nxt = ~level_nxt & BTN_LEVEL;

   // Active-low synchroniser bits reset to 1 so an idle pin does not look pressed.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_p0     <= ACTIVE_LOW;
         sync_p1     <= ACTIVE_LOW;
         BTN_LEVEL   <= '0;
         BTN_PRESS   <= '0;
         BTN_RELEASE <= '0;
         BTN_LONG    <= '0;
         PRESS_COUNT <= '0;
         for (int i = 0; i < NBTN; i++) begin
            dcnt[i]  <= '0;
            lcnt[i]  <= '0;
            state[i] <= IDLE;
         end
      end else begin
         sync_p0     <= BTN_RAW;
         sync_p1     <= sync_p0;
         BTN_LEVEL   <= level_nxt;
         PRESS_COUNT <= PRESS_COUNT + popcount(press_nxt);
         for (int i = 0; i < NBTN; i++) begin
            if ((norm[i] == BTN_LEVEL[i]) || (&dcnt[i])) dcnt[i] <= '0;
            else                                          dcnt[i] <= dcnt[i] + DEBOUNCE_LOG2'(1);

            BTN_PRESS[i]   <= 1'b0;
            BTN_RELEASE[i] <= 1'b0;
            BTN_LONG[i]    <= 1'b0;
            case (state[i])
               IDLE: begin
                  if (press_nxt[i]) begin
                     state[i]     <= DOWN;
                     lcnt[i]      <= '0;
                     BTN_PRESS[i] <= 1'b1;
                  end
               end
               DOWN: begin
                  // A release on the threshold cycle suppresses the long pulse.
                  if (release_nxt[i]) begin
                     state[i]       <= IDLE;
                     BTN_RELEASE[i] <= 1'b1;
                  end else if (&lcnt[i]) begin
                     state[i]    <= HELD;
                     BTN_LONG[i] <= 1'b1;
                  end else begin
                     lcnt[i] <= lcnt[i] + LONG_LOG2'(1);
                  end
               end
               HELD: begin
                  if (release_nxt[i]) begin
                     state[i]       <= IDLE;
                     BTN_RELEASE[i] <= 1'b1;
                  end
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce (2^3) and long (2^6) thresholds.
module tb_button_conditioner;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [3:0] BTN_RAW;
   logic [3:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;
   logic [7:0] PRESS_COUNT;

   int n_asserts = 0;
   int n_fails   = 0;

   always #5 CLK = ~CLK;

   button_conditioner #(
      .NBTN(4), .ACTIVE_LOW(4'b0001), .DEBOUNCE_LOG2(3), .LONG_LOG2(6)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .BTN_RAW(BTN_RAW),
      .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE),
      .BTN_LONG(BTN_LONG), .PRESS_COUNT(PRESS_COUNT)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_press"},   {4'd0, BTN_PRESS},   8'h00);
      chk({tag, "_release"}, {4'd0, BTN_RELEASE}, 8'h00);
      chk({tag, "_long"},    {4'd0, BTN_LONG},    8'h00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset with BTN_N idle high
      RST_N   = 1'b0;
      BTN_RAW = 4'b0001;
      tick(3);
      chk("rst_level", {4'd0, BTN_LEVEL}, 8'h00);
      chk_quiet("rst");
      chk("rst_count", PRESS_COUNT, 8'd0);
      RST_N = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk_quiet("al_idle");
         chk("al_idle_level", {4'd0, BTN_LEVEL}, 8'h00);
      end

      // Clean press on BTN1
      BTN_RAW[1] = 1'b1;
      tick(9);
      chk("clean_early_level", {4'd0, BTN_LEVEL}, 8'h00);
      chk("clean_early_press", {4'd0, BTN_PRESS}, 8'h00);
      tick(1);
      chk("clean_level", {4'd0, BTN_LEVEL}, 8'h02);
      chk("clean_press", {4'd0, BTN_PRESS}, 8'h02);
      chk("clean_count", PRESS_COUNT, 8'd1);
      tick(1);
      chk("clean_press_1cyc", {4'd0, BTN_PRESS}, 8'h00);
      chk("clean_level_hold", {4'd0, BTN_LEVEL}, 8'h02);
      BTN_RAW[1] = 1'b0;
      tick(9);
      chk("clean_early_rel", {4'd0, BTN_RELEASE}, 8'h00);
      tick(1);
      chk("clean_rel", {4'd0, BTN_RELEASE}, 8'h02);
      chk("clean_rel_level", {4'd0, BTN_LEVEL}, 8'h00);

      // Bouncing BTN2: toggles every 3 cycles, never long enough to debounce
      for (int i = 0; i < 40; i++) begin
         BTN_RAW[2] = ((i / 3) % 2 == 0);
         tick(1);
         chk_quiet("bounce");
         chk("bounce_level", {4'd0, BTN_LEVEL}, 8'h00);
      end
      BTN_RAW[2] = 1'b1;
      tick(9);
      chk("bounce_early_press", {4'd0, BTN_PRESS}, 8'h00);
      tick(1);
      chk("bounce_press", {4'd0, BTN_PRESS}, 8'h04);
      chk("bounce_count", PRESS_COUNT, 8'd2);
      BTN_RAW[2] = 1'b0;
      tick(10);
      chk("bounce_rel", {4'd0, BTN_RELEASE}, 8'h04);

      // Long press on BTN3, held 100 cycles
      BTN_RAW[3] = 1'b1;
      tick(10);
      chk("long_press", {4'd0, BTN_PRESS}, 8'h08);
      chk("long_count", PRESS_COUNT, 8'd3);
      for (int i = 0; i < 63; i++) begin
         tick(1);
         chk("long_early", {4'd0, BTN_LONG}, 8'h00);
      end
      tick(1);
      chk("long_pulse", {4'd0, BTN_LONG}, 8'h08);
      for (int i = 0; i < 26; i++) begin
         tick(1);
         chk("long_once", {4'd0, BTN_LONG}, 8'h00);
      end
      BTN_RAW[3] = 1'b0;
      tick(9);
      chk("long_early_rel", {4'd0, BTN_RELEASE}, 8'h00);
      tick(1);
      chk("long_rel", {4'd0, BTN_RELEASE}, 8'h08);
      chk("long_rel_level", {4'd0, BTN_LEVEL}, 8'h00);

      // Active-low BTN_N
      BTN_RAW[0] = 1'b0;
      tick(9);
      chk("al_early_press", {4'd0, BTN_PRESS}, 8'h00);
      tick(1);
      chk("al_press", {4'd0, BTN_PRESS}, 8'h01);
      chk("al_level", {4'd0, BTN_LEVEL}, 8'h01);
      chk("al_count", PRESS_COUNT, 8'd4);
      BTN_RAW[0] = 1'b1;
      tick(10);
      chk("al_rel", {4'd0, BTN_RELEASE}, 8'h01);
      chk("al_rel_level", {4'd0, BTN_LEVEL}, 8'h00);

      // Preload 254 presses, then three simultaneous presses wrap the counter
      RST_N = 1'b0;
      tick(2);
      chk("wrap_rst_count", PRESS_COUNT, 8'd0);
      RST_N = 1'b1;
      for (int i = 0; i < 254; i++) begin
         BTN_RAW[1] = 1'b1;
         tick(12);
         BTN_RAW[1] = 1'b0;
         tick(12);
      end
      chk("preload_count", PRESS_COUNT, 8'd254);
      BTN_RAW[3:1] = 3'b111;
      tick(9);
      chk("simul_early_press", {4'd0, BTN_PRESS}, 8'h00);
      tick(1);
      chk("simul_press", {4'd0, BTN_PRESS}, 8'h0e);
      chk("simul_level", {4'd0, BTN_LEVEL}, 8'h0e);
      chk("wrap_count", PRESS_COUNT, 8'd1);

      // Asynchronous reset while BTN1 is held
      RST_N = 1'b0;
      BTN_RAW[3:2] = 2'b00;
      #2;
      chk("async_rst_level", {4'd0, BTN_LEVEL}, 8'h00);
      chk_quiet("async_rst");
      chk("async_rst_count", PRESS_COUNT, 8'd0);
      tick(2);
      RST_N = 1'b1;
      tick(9);
      chk("rehold_early_press", {4'd0, BTN_PRESS}, 8'h00);
      tick(1);
      chk("rehold_press", {4'd0, BTN_PRESS}, 8'h02);
      chk("rehold_level", {4'd0, BTN_LEVEL}, 8'h02);
      chk("rehold_count", PRESS_COUNT, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
